spi_xfer_scheduler: RTL and testbench

SPI_XFER_SCHEDULER -- requirements
Module: spi_xfer_scheduler

---
 rtl/spi_pkg.sv | 64 ++++++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/spi_xfer_scheduler.sv | 163 ++++++++++++++++
 tb/tb_spi_xfer_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer scheduler: FSM states,
// SPI master register offsets, command byte layout and the ready timeout.
package spi_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SEL,
    TX0,
    WAIT0,
    TX1,
    WAIT1,
    RX,
    DESEL,
    RESP
  } state_t;

  localparam logic [4:0] REG_SS     = 5'd0;
  localparam logic [4:0] REG_TX     = 5'd1;
  localparam logic [4:0] REG_STATUS = 5'd2;
  localparam logic [4:0] REG_RX     = 5'd3;

  localparam int         CMD_WR_BIT     = 7;
  localparam int         TIMEOUT_CYCLES = 1024;
  localparam int         TIMEOUT_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0] TIMEOUT_RDATA  = 8'hFF;

  // One access on the SPI master register bus, held for a single cycle.
  typedef struct packed {
    logic        cs;
    logic        write;
    logic        read;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '0;

  function automatic bus_t bus_write(input logic [4:0] addr, input logic [31:0] data);
    bus_t b;
    b       = BUS_IDLE;
    b.cs    = 1'b1;
    b.write = 1'b1;
    b.addr  = addr;
    b.wdata = data;
    return b;
  endfunction

  function automatic bus_t bus_read(input logic [4:0] addr);
    bus_t b;
    b      = BUS_IDLE;
    b.cs   = 1'b1;
    b.read = 1'b1;
    b.addr = addr;
    return b;
  endfunction

  function automatic logic [7:0] cmd_byte(input logic wr, input logic [3:0] addr);
    logic [7:0] c;
    c             = {4'b0000, addr};
    c[CMD_WR_BIT] = wr;
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted
// most recently wins. The pointer advances only on the update strobe.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    // NOTE: assigning a default before any branch keeps this block purely combinational (no latch).
    grant = 2'b00;
    if (req[0] && (!req[1] || last)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  // Reset to "requester 1 last granted" so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= 1'b1;
    end else if (update && (|grant)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Arbitrates two register-access requesters and sequences each one as a
// two-byte SPI transaction through the SPI master's register bus.
module spi_xfer_scheduler
  import spi_pkg::*;
#(
  parameter int SS_WIDTH = 2,
  parameter int SS_IDX   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [1:0]  req_wr,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  gnt,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        m_cs,
  output logic        m_write,
  output logic        m_read,
  output logic [4:0]  m_reg_addr,
  output logic [31:0] m_wr_data,
  input  logic [31:0] m_rd_data
);

  localparam logic [SS_WIDTH-1:0] SS_SELECT      = ~(SS_WIDTH'(1) << SS_IDX);
  localparam logic [31:0]         SS_SELECT_WORD = 32'(SS_SELECT);
  localparam logic [31:0]         SS_IDLE_WORD   = 32'({SS_WIDTH{1'b1}});

  state_t               state;
  bus_t                 bus_q;
  logic                 id_q;
  logic                 wr_q;
  logic [3:0]           addr_q;
  logic [7:0]           wdata_q;
  logic [7:0]           rdata_q;
  logic [TIMEOUT_W-1:0] to_cnt;

  logic [1:0] arb_gnt;
  logic       arb_id;
  logic       arb_update;
  logic       unused_rd_upper;

  assign arb_update      = (state == IDLE) && (|req);
  assign arb_id          = arb_gnt[1];
  assign unused_rd_upper = ^m_rd_data[31:8];

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .update  (arb_update),
    .grant   (arb_gnt)
  );

  assign m_cs       = bus_q.cs;
  assign m_write    = bus_q.write;
  assign m_read     = bus_q.read;
  assign m_reg_addr = bus_q.addr;
  assign m_wr_data  = bus_q.wdata;

  // Each state's bus access is loaded on the transition into that state, so
  // strobes are registered and last exactly one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bus_q     <= BUS_IDLE;
      gnt       <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rdata <= 8'h00;
      busy      <= 1'b0;
      id_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 4'h0;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      to_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every branch sees the pre-edge register values.
      bus_q     <= BUS_IDLE;
      gnt       <= 2'b00;
      rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (|req) begin
            state   <= SEL;
            busy    <= 1'b1;
            gnt     <= arb_gnt;
            id_q    <= arb_id;
            wr_q    <= arb_id ? req_wr[1]        : req_wr[0];
            addr_q  <= arb_id ? req_addr[7:4]    : req_addr[3:0];
            wdata_q <= arb_id ? req_wdata[15:8]  : req_wdata[7:0];
            bus_q   <= bus_write(REG_SS, SS_SELECT_WORD);
          end
        end

        SEL: begin
          state <= TX0;
          bus_q <= bus_write(REG_TX, 32'(cmd_byte(wr_q, addr_q)));
        end

        TX0: begin
          state  <= WAIT0;
          to_cnt <= '0;
          bus_q  <= bus_read(REG_STATUS);
        end

        WAIT0, WAIT1: begin
          if (m_rd_data[0]) begin
            if (state == WAIT0) begin
              state <= TX1;
              bus_q <= bus_write(REG_TX, 32'(wr_q ? wdata_q : 8'h00));
            end else begin
              state <= RX;
              bus_q <= bus_read(REG_RX);
            end
          end else if (to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            state   <= DESEL;
            rdata_q <= TIMEOUT_RDATA;
            bus_q   <= bus_write(REG_SS, SS_IDLE_WORD);
          end else begin
            to_cnt <= to_cnt + 1'b1;
            bus_q  <= bus_read(REG_STATUS);
          end
        end

        TX1: begin
          state  <= WAIT1;
          to_cnt <= '0;
          bus_q  <= bus_read(REG_STATUS);
        end

        RX: begin
          state   <= DESEL;
          rdata_q <= wr_q ? 8'h00 : m_rd_data[7:0];
          bus_q   <= bus_write(REG_SS, SS_IDLE_WORD);
        end

        DESEL: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_rdata <= rdata_q;
        end

        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Directed bench for spi_xfer_scheduler with a behavioural SPI master plus
// 16x8 slave register file on the register bus and a shadow memory.
module tb_spi_xfer_scheduler;

  localparam int XFER_CYCLES = 3;
  localparam int NORMAL_LAT  = 13;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req;
  logic [1:0]  req_wr;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  gnt;
  logic        rsp_valid;
  logic        rsp_id;
  logic [7:0]  rsp_rdata;
  logic        busy;
  logic        m_cs;
  logic        m_write;
  logic        m_read;
  logic [4:0]  m_reg_addr;
  logic [31:0] m_wr_data;
  logic [31:0] m_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_xfer_scheduler #(.SS_WIDTH(2), .SS_IDX(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .m_cs       (m_cs),
    .m_write    (m_write),
    .m_read     (m_read),
    .m_reg_addr (m_reg_addr),
    .m_wr_data  (m_wr_data),
    .m_rd_data  (m_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SPI master + slave register file model: reg0 drives ss_n, reg1 shifts one
  // byte (cmd then data) taking XFER_CYCLES, reg2 bit0 = ready, reg3 = RX byte.
  logic [1:0] ss_n;
  logic [7:0] mem [16];
  logic [2:0] xfer_cnt;
  logic       byte_idx;
  logic [7:0] cmd_q;
  logic [7:0] rx_byte;
  bit         mem_loaded = 1'b0;
  bit         force_not_ready = 1'b0;
  logic       ready;

  assign ready = (xfer_cnt == 3'd0) && !force_not_ready;

  always_comb begin
    m_rd_data = 32'h0;
    if (m_reg_addr == 5'd2) m_rd_data = {31'h0, ready};
    else if (m_reg_addr == 5'd3) m_rd_data = {24'h0, rx_byte};
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_n     <= 2'b11;
      xfer_cnt <= 3'd0;
      byte_idx <= 1'b0;
      cmd_q    <= 8'h00;
      rx_byte  <= 8'h00;
      if (!mem_loaded) begin
        for (int i = 0; i < 16; i++) mem[i] <= 8'hC0 | 8'(i);
        mem_loaded <= 1'b1;
      end
    end else begin
      if (xfer_cnt != 3'd0) xfer_cnt <= xfer_cnt - 3'd1;
      if (m_cs && m_write && m_reg_addr == 5'd0) begin
        ss_n     <= m_wr_data[1:0];
        byte_idx <= 1'b0;
      end
      if (m_cs && m_write && m_reg_addr == 5'd1 && !ss_n[0]) begin
        xfer_cnt <= 3'(XFER_CYCLES);
        byte_idx <= 1'b1;
        if (!byte_idx) begin
          cmd_q   <= m_wr_data[7:0];
          rx_byte <= 8'hFF;
        end else if (cmd_q[7]) begin
          mem[cmd_q[3:0]] <= m_wr_data[7:0];
          rx_byte         <= 8'h00;
        end else begin
          rx_byte <= mem[cmd_q[3:0]];
        end
      end
    end
  end

  // Bus-protocol and grant monitor.
  logic prev_busy;
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_busy <= 1'b0;
    end else begin
      prev_busy <= busy;
      if (m_cs || m_write || m_read) begin
        check("bus_one_strobe", 32'(m_cs && (m_write ^ m_read)), 32'd1);
        check("bus_not_idle_resp", 32'(busy && !rsp_valid), 32'd1);
        check("bus_wdata_zero_ext", m_wr_data[31:8], 32'd0);
      end
      if (gnt != 2'b00) begin
        check("gnt_onehot", 32'($countones(gnt)), 32'd1);
        check("gnt_not_while_busy", 32'(prev_busy), 32'd0);
      end
      if (!busy) check("ss_released_when_idle", 32'(ss_n), 32'h3);
    end
  end

  logic [7:0] shadow [16];
  logic [1:0] got_gnt;
  logic [7:0] got_rdata;
  logic       got_id;
  int         lat;

  task automatic wait_gnt();
    int n = 0;
    while (gnt == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("gnt_arrived", 32'(gnt != 2'b00), 32'd1);
    got_gnt = gnt;
  endtask

  task automatic wait_rsp();
    lat = 0;
    while (!rsp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_arrived", 32'(rsp_valid), 32'd1);
    got_rdata = rsp_rdata;
    got_id    = rsp_id;
  endtask

  task automatic post_req(input int id, input logic wr, input logic [3:0] a, input logic [7:0] d);
    if (id == 0) begin
      req_wr[0] = wr; req_addr[3:0] = a; req_wdata[7:0] = d; req[0] = 1'b1;
    end else begin
      req_wr[1] = wr; req_addr[7:4] = a; req_wdata[15:8] = d; req[1] = 1'b1;
    end
  endtask

  task automatic xfer(input int id, input logic wr, input logic [3:0] a, input logic [7:0] d);
    post_req(id, wr, a, d);
    wait_gnt();
    req = 2'b00;
    wait_rsp();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_strobes"}, 32'({m_cs, m_write, m_read}), 32'd0);
    check({tag, "_reg_addr"}, 32'(m_reg_addr), 32'd0);
    check({tag, "_wr_data"}, m_wr_data, 32'd0);
  endtask

  initial begin
    logic [3:0] ra;
    logic [7:0] rd;
    logic       rw;
    int         rid;

    req = 2'b00; req_wr = 2'b00; req_addr = 8'h00; req_wdata = 16'h0000;
    for (int i = 0; i < 16; i++) shadow[i] = 8'hC0 | 8'(i);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Scenario 1: write 0xA5 to addr 3, read it back, data held afterwards.
    xfer(0, 1'b1, 4'd3, 8'hA5);
    shadow[3] = 8'hA5;
    check("s1_wr_gnt", 32'(got_gnt), 32'h1);
    check("s1_wr_id", 32'(got_id), 32'd0);
    check("s1_wr_rdata", 32'(got_rdata), 32'h00);
    check("s1_wr_latency", 32'(lat), 32'(NORMAL_LAT));
    xfer(0, 1'b0, 4'd3, 8'h00);
    check("s1_rd_rdata", 32'(got_rdata), 32'hA5);
    check("s1_rd_id", 32'(got_id), 32'd0);
    repeat (4) @(negedge clk);
    check("s1_rdata_held", 32'(rsp_rdata), 32'hA5);
    check("s1_valid_pulse", 32'(rsp_valid), 32'd0);

    // Scenario 2: fresh reset, both requesters read addr 3 continuously.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    post_req(0, 1'b0, 4'd3, 8'h00);
    post_req(1, 1'b0, 4'd3, 8'h00);
    for (int k = 0; k < 4; k++) begin
      wait_gnt();
      if (k == 3) req = 2'b00;
      check("s2_gnt_seq", 32'(got_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      wait_rsp();
      check("s2_rsp_id", 32'(got_id), (k % 2 == 0) ? 32'd0 : 32'd1);
      check("s2_rdata", 32'(got_rdata), 32'hA5);
    end
    @(negedge clk);

    // Scenario 3: read preloaded addr 15, slave selected only inside the transaction.
    post_req(1, 1'b0, 4'd15, 8'h00);
    wait_gnt();
    req = 2'b00;
    check("s3_ss_before_sel", 32'(ss_n), 32'h3);
    @(negedge clk);
    check("s3_ss_selected", 32'(ss_n), 32'h2);
    wait_rsp();
    check("s3_ss_after_desel", 32'(ss_n), 32'h3);
    check("s3_rdata", 32'(got_rdata), 32'hCF);
    check("s3_rsp_id", 32'(got_id), 32'd1);

    // Scenario 4: never ready; a write of 0x77 to addr 3 must time out unapplied.
    force_not_ready = 1'b1;
    xfer(0, 1'b1, 4'd3, 8'h77);
    force_not_ready = 1'b0;
    check("s4_timeout_window", 32'(lat >= 1024 && lat <= 1030), 32'd1);
    check("s4_timeout_rdata", 32'(got_rdata), 32'hFF);
    @(negedge clk);

    // Scenario 5: reset pulsed during WAIT1 of a read.
    post_req(0, 1'b0, 4'd15, 8'h00);
    wait_gnt();
    req = 2'b00;
    repeat (8) @(negedge clk);
    check("s5_in_wait1_busy", 32'(busy), 32'd1);
    check("s5_in_wait1_status_rd", 32'({m_read, m_reg_addr}), 32'({1'b1, 5'd2}));
    reset_n = 1'b0;
    #1 check_all_zero("s5_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("s5_ss_released", 32'(ss_n), 32'h3);
    xfer(1, 1'b0, 4'd3, 8'h00);
    check("s5_after_rdata", 32'(got_rdata), 32'hA5);
    check("s5_after_id", 32'(got_id), 32'd1);

    // Scenario 6: random reads and writes from both requesters against the shadow.
    for (int k = 0; k < 500; k++) begin
      rid = int'($urandom_range(1, 0));
      rw  = 1'($urandom_range(1, 0));
      ra  = 4'($urandom_range(15, 0));
      rd  = 8'($urandom_range(255, 0));
      xfer(rid, rw, ra, rd);
      check("s6_rsp_id", 32'(got_id), 32'(rid));
      if (rw) begin
        check("s6_wr_rdata", 32'(got_rdata), 32'h00);
        shadow[ra] = rd;
      end else begin
        check("s6_rd_rdata", 32'(got_rdata), 32'(shadow[ra]));
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
